// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - 3-stage pipelined sign/exp/mant multiplier with rounding modes, tag and sticky flags
module fp_mult_pipe #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [1:0]               in_rm,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [4:0]               out_flags,
    output logic [4:0]               flags_sticky,
    input  logic                     flags_clr
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX = 2 ** EXP_W - 2;
    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    logic advance;

    // stage 1 state
    logic                    v1_q, sign1_q, nan1_q, inf1_q, zero1_q;
    logic signed [EW-1:0]    e1_q;
    logic [PW-1:0]           prod1_q;
    logic [1:0]              rm1_q;
    logic [TAG_W-1:0]        tag1_q;
    logic                    sign1_d, nan1_d, inf1_d, zero1_d;
    logic signed [EW-1:0]    e1_d;
    logic [PW-1:0]           prod1_d;

    // stage 2 state
    logic                    v2_q, sign2_q, nan2_q, inf2_q, zero2_q, inexact2_q;
    logic signed [EW-1:0]    e2_q;
    logic [MAN_W-1:0]        mant2_q;
    logic [1:0]              rm2_q;
    logic [TAG_W-1:0]        tag2_q;
    logic signed [EW-1:0]    e2_d;
    logic [MAN_W-1:0]        mant2_d;
    logic                    inexact2_d;

    // output stage state
    logic                    out_valid_q;
    logic [W-1:0]            out_result_q, out_result_d;
    logic [TAG_W-1:0]        out_tag_q;
    logic [4:0]              out_flags_q, out_flags_d;
    logic [4:0]              sticky_q;

    assign advance      = !out_valid_q || out_ready;
    assign in_ready     = advance;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_tag      = out_tag_q;
    assign out_flags    = out_flags_q;
    assign flags_sticky = sticky_q;

    always_comb begin
        logic [EXP_W-1:0] ea, eb;
        logic [MAN_W-1:0] ma, mb;
        logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
        ea      = in_a[W-2:MAN_W];
        eb      = in_b[W-2:MAN_W];
        ma      = in_a[MAN_W-1:0];
        mb      = in_b[MAN_W-1:0];
        a_nan   = (&ea) && (|ma);
        a_inf   = (&ea) && !(|ma);
        a_zero  = !(|ea) && !(|ma);
        b_nan   = (&eb) && (|mb);
        b_inf   = (&eb) && !(|mb);
        b_zero  = !(|eb) && !(|mb);
        sign1_d = in_a[W-1] ^ in_b[W-1];
        nan1_d  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
        inf1_d  = a_inf || b_inf;
        zero1_d = a_zero || b_zero;
        e1_d    = {2'b00, ea} + {2'b00, eb} - EW'(BIAS);
        prod1_d = PW'({1'b1, ma}) * PW'({1'b1, mb});
    end

    always_comb begin
        logic             norm, g, st, up;
        logic [PW-1:0]    shifted;
        logic [MAN_W-1:0] kept;
        logic [MAN_W:0]   mant_r;
        norm    = prod1_q[PW-1];
        shifted = norm ? prod1_q : {prod1_q[PW-2:0], 1'b0};
        // leading 1 now sits at bit PW-1; fraction bits follow it
        kept    = shifted[PW-2 -: MAN_W];
        g       = shifted[MAN_W];
        st      = |shifted[MAN_W-1:0];
        case (rm1_q)
            RM_RNE:  up = g && (st || kept[0]);
            RM_RTZ:  up = 1'b0;
            RM_RUP:  up = !sign1_q && (g || st);
            default: up = sign1_q && (g || st);
        endcase
        mant_r     = {1'b0, kept} + {{MAN_W{1'b0}}, up};
        e2_d       = e1_q + {{(EW-1){1'b0}}, norm} + {{(EW-1){1'b0}}, mant_r[MAN_W]};
        mant2_d    = mant_r[MAN_W-1:0];
        inexact2_d = g || st;
    end

    always_comb begin
        logic to_inf;
        to_inf = (rm2_q == RM_RNE) || (rm2_q == RM_RUP && !sign2_q) ||
                 (rm2_q == RM_RDN && sign2_q);
        out_result_d = '0;
        out_flags_d  = '0;
        if (nan2_q) begin
            out_result_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            out_flags_d  = 5'b10000;
        end else if (inf2_q) begin
            out_result_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero2_q) begin
            out_result_d = {sign2_q, {(W-1){1'b0}}};
        end else if (e2_q > EMAX_S) begin
            out_flags_d  = 5'b00101;
            out_result_d = to_inf ? {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                  : {sign2_q, EXP_W'(EMAX), {MAN_W{1'b1}}};
        end else if (e2_q[EW-1]) begin
            out_result_d = {sign2_q, {(W-1){1'b0}}};
            out_flags_d  = 5'b00011;
        end else begin
            out_result_d = {sign2_q, e2_q[EXP_W-1:0], mant2_q};
            out_flags_d  = {4'b0000, inexact2_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0; sign1_q <= 1'b0; nan1_q <= 1'b0; inf1_q <= 1'b0; zero1_q <= 1'b0;
            e1_q <= '0; prod1_q <= '0; rm1_q <= '0; tag1_q <= '0;
            v2_q <= 1'b0; sign2_q <= 1'b0; nan2_q <= 1'b0; inf2_q <= 1'b0; zero2_q <= 1'b0;
            inexact2_q <= 1'b0; e2_q <= '0; mant2_q <= '0; rm2_q <= '0; tag2_q <= '0;
            out_valid_q <= 1'b0; out_result_q <= '0; out_tag_q <= '0; out_flags_q <= '0;
            sticky_q <= '0;
        end else begin
            if (advance) begin
                v1_q    <= in_valid;
                sign1_q <= sign1_d;
                nan1_q  <= nan1_d;
                inf1_q  <= inf1_d;
                zero1_q <= zero1_d;
                e1_q    <= e1_d;
                prod1_q <= prod1_d;
                rm1_q   <= in_rm;
                tag1_q  <= in_tag;
                v2_q       <= v1_q;
                sign2_q    <= sign1_q;
                nan2_q     <= nan1_q;
                inf2_q     <= inf1_q;
                zero2_q    <= zero1_q;
                inexact2_q <= inexact2_d;
                e2_q       <= e2_d;
                mant2_q    <= mant2_d;
                rm2_q      <= rm1_q;
                tag2_q     <= tag1_q;
                out_valid_q  <= v2_q;
                out_result_q <= out_result_d;
                out_tag_q    <= tag2_q;
                out_flags_q  <= out_flags_d;
            end
            // a clear coinciding with an accepted result keeps only that result's flags
            if (flags_clr) begin
                sticky_q <= (out_valid_q && out_ready) ? out_flags_q : 5'b00000;
            end else if (out_valid_q && out_ready) begin
                sticky_q <= sticky_q | out_flags_q;
            end
        end
    end
endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, pipelined successor of the team's combinational FP8 (E3M4) multiplier.
- Supports generic exponent/mantissa widths, a per-operation rounding mode, valid/ready handshaking with backpressure, a pass-through tag and sticky exception flags.
- Sits between the operand issue logic and the result writeback/accumulate path of the low-precision datapath.

Parameters:
- EXP_W, 3, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 4, stored mantissa width (implicit leading 1).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_a  in  1+EXP_W+MAN_W  operand A {sign, exp, mant}
- in_b  in  1+EXP_W+MAN_W  operand B
- in_rm  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf)
- in_tag  in  TAG_W  tag, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  1+EXP_W+MAN_W  product
- out_tag  out  TAG_W  tag of this result
- out_flags  out  5  {invalid, divzero(always 0), overflow, underflow, inexact} for this result
- flags_sticky  out  5  OR of out_flags over all accepted results
- flags_clr  in  1  clear flags_sticky

Behaviour:
- Reset (rst_n low at posedge): all pipeline valids, out_valid, out_result, out_tag, out_flags and flags_sticky are 0. A reset mid-operation discards every in-flight operation. in_ready is high from the first cycle after reset.
- Pipeline: 3 registered stages.
  - S1: decode specials, sign XOR, exponent sum, (MAN_W+1)x(MAN_W+1) mantissa product.
  - S2: normalise, round, exponent adjust.
  - S3: overflow/underflow/special select, pack, flags.
- Latency is 3 cycles from input accept to out_valid with out_ready held high. Throughput is 1 operation per cycle.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - Input is accepted when in_valid && in_ready.
  - When advance is low, all stages hold and outputs stay stable.
  - Bubbles are not collapsed. Results emerge in input order.
- Encoding:
  - exp all-ones with mant != 0 is NaN; with mant == 0 it is inf.
  - exp == 0 with mant == 0 is zero.
  - Every other encoding, including exp == 0 with mant != 0, is a normal with implicit 1. There are no subnormals.
  - Max normal encoded exp is 2^EXP_W-2.
- Arithmetic:
  - The product is 2*MAN_W+2 bits. If its MSB is set, exp += 1 and the value is taken from the MSB; otherwise it is shifted left by 1.
  - Kept mantissa = MAN_W bits after the leading 1. g = next bit; s = OR of the remaining bits.
  - Round up: RNE g&(s|lsb); RTZ 0; RUP !sign&(g|s); RDN sign&(g|s).
  - A mantissa carry-out increments the exponent.
  - Internal exponent is signed, width EXP_W+2: e = ea + eb - bias + norm + carry.
- Result priority (highest first):
  1. NaN: either input NaN, or inf x zero. Result {sign, all-ones, all-ones}; invalid=1.
  2. inf: either input inf. Result {sign, all-ones, 0}; no flags.
  3. zero: either input zero. Result {sign, 0, 0}; no flags.
  4. overflow: e > 2^EXP_W-2. overflow=1, inexact=1. Result is inf for RNE, for RUP when sign=0, and for RDN when sign=1. Otherwise it is max finite {sign, 2^EXP_W-2, all-ones}.
  5. underflow: e < 0. Result {sign, 0, 0}; underflow=1, inexact=1.
  6. normal: {sign, e[EXP_W-1:0], mant}; inexact = g|s.
- Sticky flags:
  - On each out_valid && out_ready cycle, flags_sticky |= out_flags.
  - When flags_clr is asserted, flags_sticky is cleared. If a result is accepted in the same cycle, flags_sticky becomes exactly that result's out_flags.

Test Plan:
- Exact product, defaults, RNE: 0x38 x 0x38 (1.5 x 1.5) -> out_result 0x42, out_flags 00000, out_valid exactly 3 cycles after accept.
- Rounding modes: 0x31 x 0x31 -> RNE 0x32 and RUP 0x33, both with flags 00001. With sign-flipped A (0xB1) -> RDN 0xB3 and RTZ 0xB2.
- Overflow: 0x6F x 0x6F -> RNE 0x70 and RTZ 0x6F, both with flags 00101. 0xEF x 0x6F in RUP -> 0xEF.
- Underflow and specials:
  - 0x10 x 0x10 -> 0x00, flags 00011.
  - 0x70 x 0x00 -> 0x7F, flags 10000.
  - 0xF0 x 0x38 -> 0xF0, flags 00000.
- Backpressure: stream 8 tagged ops with out_ready low for cycles 4-8. Required: outputs held stable, in_ready low while stalled, no loss or duplication, tags returned in order.
- Sticky and reset:
  - An overflow op, then a clean op, gives flags_sticky 00101.
  - flags_clr asserted in the same cycle as an underflow result is accepted gives flags_sticky 00011.
  - rst_n low with 3 ops in flight drops all of them: out_valid 0 and flags_sticky 0 on the next cycle.
